// File: rtl/advanced_pulse_extender.sv
// Multi-channel retriggerable pulse extender with per-channel missed-trigger flag.
// Define ADVANCED_PULSE_EXTENDER_HOLDOFF_EN to add a forced-low holdoff after each pulse.
module advanced_pulse_extender #(
   parameter int CHANNELS       = 1,
   parameter int LENGTH_WIDTH   = 4,
   parameter int RETRIGGER      = 1,
   parameter int HOLDOFF_LENGTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [LENGTH_WIDTH-1:0] pulse_length,
   input  logic [CHANNELS-1:0]     pulse_in,
   output logic [CHANNELS-1:0]     pulse_out,
   output logic [CHANNELS-1:0]     missed
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [LENGTH_WIDTH-1:0] ONE = 1;

`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
   localparam logic [1:0] HOLDOFF = 2'd2;
   localparam int HW = (HOLDOFF_LENGTH > 1) ? $clog2(HOLDOFF_LENGTH) : 1;
   localparam logic [HW-1:0] HOLD_LOAD =
      HW'((HOLDOFF_LENGTH > 0) ? HOLDOFF_LENGTH - 1 : 0);
`else
   localparam int unused_holdoff = HOLDOFF_LENGTH;
`endif

   // Counter holds remaining high cycles after the current one; length 0 acts as 1.
   logic [LENGTH_WIDTH-1:0] load_value;

   assign load_value = (pulse_length == '0) ? '0 : pulse_length - ONE;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [1:0]              state;
      logic [LENGTH_WIDTH-1:0] count;
      logic                    out_r;
      logic                    miss_r;
`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
      logic [HW-1:0]           hold_count;
`endif

      assign pulse_out[i] = out_r;
      assign missed[i]    = miss_r;

      always_ff @(posedge clock) begin
         if (reset) begin
            state  <= IDLE;
            count  <= '0;
            out_r  <= 1'b0;
            miss_r <= 1'b0;
`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
            hold_count <= '0;
`endif
         end else begin
            miss_r <= 1'b0;
            case (state)
               IDLE: begin
                  if (pulse_in[i]) begin
                     state <= ACTIVE;
                     count <= load_value;
                     out_r <= 1'b1;
                  end
               end
               ACTIVE: begin
                  if (pulse_in[i] && RETRIGGER != 0) begin
                     count <= load_value;
                  end else begin
                     if (pulse_in[i])
                        miss_r <= 1'b1;
                     if (count == '0) begin
                        out_r <= 1'b0;
`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
                        if (HOLDOFF_LENGTH == 0) begin
                           state <= IDLE;
                        end else begin
                           state      <= HOLDOFF;
                           hold_count <= HOLD_LOAD;
                        end
`else
                        state <= IDLE;
`endif
                     end else begin
                        count <= count - ONE;
                     end
                  end
               end
`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
               HOLDOFF: begin
                  miss_r <= pulse_in[i];
                  if (hold_count == '0)
                     state <= IDLE;
                  else
                     hold_count <= hold_count - 1'b1;
               end
`endif
               default: begin
                  state <= IDLE;
                  out_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_advanced_pulse_extender.sv
// Directed and model-based checks for advanced_pulse_extender.
// Two instances: A retriggers (no holdoff), B ignores retriggers (holdoff 2 if enabled).
module tb_advanced_pulse_extender;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] pulse_length;
   logic [3:0] pin_a, pin_b;
   logic [3:0] out_a, miss_a, out_b, miss_b;
   int         checks = 0;
   int         passed = 0;

   always #5 clock = ~clock;

   advanced_pulse_extender #(
      .CHANNELS(4), .LENGTH_WIDTH(4), .RETRIGGER(1), .HOLDOFF_LENGTH(0)
   ) dut_a (
      .clock(clock), .reset(reset), .pulse_length(pulse_length),
      .pulse_in(pin_a), .pulse_out(out_a), .missed(miss_a)
   );

   advanced_pulse_extender #(
      .CHANNELS(4), .LENGTH_WIDTH(4), .RETRIGGER(0), .HOLDOFF_LENGTH(2)
   ) dut_b (
      .clock(clock), .reset(reset), .pulse_length(pulse_length),
      .pulse_in(pin_b), .pulse_out(out_b), .missed(miss_b)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // bit i of trig/exp vectors = edge i of the sequence
   task automatic seq(input string tag, input bit use_b, input int ch,
                      input logic [3:0] l0, input logic [3:0] l1,
                      input logic [31:0] trig, input logic [31:0] eo,
                      input logic [31:0] em, input int n);
      for (int i = 0; i < n; i++) begin
         pulse_length = (i == 0) ? l0 : l1;
         pin_a = '0;
         pin_b = '0;
         if (use_b) pin_b[ch] = trig[i];
         else       pin_a[ch] = trig[i];
         step();
         check($sformatf("%s out@%0d", tag, i),
               use_b ? 32'(out_b[ch]) : 32'(out_a[ch]), 32'(eo[i]));
         check($sformatf("%s miss@%0d", tag, i),
               use_b ? 32'(miss_b[ch]) : 32'(miss_a[ch]), 32'(em[i]));
      end
      pin_a = '0;
      pin_b = '0;
   endtask

   // Reference: e is the first edge at which the pulse is low again.
   int end_a[4], end_b[4];

   task automatic model(input bit r, input bit rt, input int h, input int t,
                        input bit p, input int len, inout int e,
                        output bit o, output bit m);
      int l;
      l = (len == 0) ? 1 : len;
      m = 1'b0;
      if (r) begin
         e = -100;
      end else if (p) begin
         if (t <= e + h) begin
            if (rt && t <= e) e = t + l;
            else              m = 1'b1;
         end else begin
            e = t + l;
         end
      end
      o = (t < e);
   endtask

   initial begin
      int hb;
      logic [3:0] eoa, ema, eob, emb;
      bit o, m;
`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
      hb = 2;
`else
      hb = 0;
`endif
      reset = 1'b1;
      pulse_length = 4'd3;
      pin_a = '0;
      pin_b = '0;
      step();
      step();
      reset = 1'b0;
      check("reset out_a", 32'(out_a), 0);
      check("reset miss_a", 32'(miss_a), 0);
      check("reset out_b", 32'(out_b), 0);
      check("reset miss_b", 32'(miss_b), 0);

      // single trigger, L=3, other channels quiet
      pin_a = 4'b0001;
      step();
      pin_a = '0;
      for (int i = 0; i < 3; i++) begin
         check("single out", 32'(out_a), 32'h1);
         check("single miss", 32'(miss_a), 0);
         step();
      end
      check("single end", 32'(out_a), 0);

      // all channels at once
      pin_a = 4'hF;
      step();
      pin_a = '0;
      for (int i = 0; i < 3; i++) begin
         check("all out", 32'(out_a), 32'hF);
         step();
      end
      check("all end", 32'(out_a), 0);

      seq("retrig", 0, 1, 4, 4, 32'h5, 32'h3F, 0, 10);
      seq("len0", 0, 0, 0, 0, 32'h1, 32'h1, 0, 3);
      seq("lenchg", 0, 3, 3, 9, 32'h1, 32'h7, 0, 6);
      seq("reload", 0, 2, 4, 2, 32'h5, 32'hF, 0, 7);
      seq("hold", 0, 1, 2, 2, 32'hFFFFF, 32'h1FFFFF, 0, 24);
`ifdef ADVANCED_PULSE_EXTENDER_HOLDOFF_EN
      seq("noretrig", 1, 2, 4, 4, 32'h25, 32'h0F, 32'h24, 11);
      seq("held_b", 1, 3, 2, 2, 32'h1FF, 32'h63, 32'h1DE, 12);
`else
      seq("noretrig", 1, 2, 4, 4, 32'h25, 32'h1EF, 32'h4, 11);
      seq("held_b", 1, 3, 2, 2, 32'h1FF, 32'hDB, 32'h1B6, 12);
`endif

      // reset in the middle of an L=15 pulse, triggers on the reset edge ignored
      pulse_length = 4'd15;
      pin_a = 4'b0001;
      step();
      pin_a = '0;
      repeat (4) step();
      check("mid pulse", 32'(out_a[0]), 1);
      reset = 1'b1;
      pin_a = 4'hF;
      pin_b = 4'hF;
      step();
      check("rst out_a", 32'(out_a), 0);
      check("rst miss_a", 32'(miss_a), 0);
      check("rst out_b", 32'(out_b), 0);
      check("rst miss_b", 32'(miss_b), 0);
      reset = 1'b0;
      pin_a = '0;
      pin_b = '0;
      step();
      check("rst trig ign a", 32'(out_a), 0);
      check("rst trig ign b", 32'(out_b), 0);
      pin_a = 4'b0001;
      step();
      pin_a = '0;
      check("post rst trig", 32'(out_a), 32'h1);

      // random triggers, lengths and resets against the reference
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         end_a[c] = -100;
         end_b[c] = -100;
      end
      for (int t = 0; t < 200; t++) begin
         reset = ($urandom_range(0, 39) == 0);
         pulse_length = 4'($urandom_range(0, 15));
         for (int c = 0; c < 4; c++) begin
            pin_a[c] = ($urandom_range(0, 3) == 0);
            pin_b[c] = ($urandom_range(0, 3) == 0);
         end
         step();
         for (int c = 0; c < 4; c++) begin
            model(reset, 1'b1, 0, t, pin_a[c], int'(pulse_length),
                  end_a[c], o, m);
            eoa[c] = o;
            ema[c] = m;
            model(reset, 1'b0, hb, t, pin_b[c], int'(pulse_length),
                  end_b[c], o, m);
            eob[c] = o;
            emb[c] = m;
         end
         check($sformatf("rnd out_a@%0d", t), 32'(out_a), 32'(eoa));
         check($sformatf("rnd miss_a@%0d", t), 32'(miss_a), 32'(ema));
         check($sformatf("rnd out_b@%0d", t), 32'(out_b), 32'(eob));
         check($sformatf("rnd miss_b@%0d", t), 32'(miss_b), 32'(emb));
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
